// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: processes one operand bit per clock, LSB first, and reports result and flags.
// Optional signed-overflow flag is built only when SERIAL_ALU_OVF_EN is defined; otherwise ovf is tied to 0.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             reclk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             is_sub, is_arith, b_eff, bit_out, c_next, last_bit;
    logic [WIDTH-1:0] res_final;

    // Single-bit slice: sub reuses the adder with b inverted and carry-in preset to 1
    always_comb begin
        is_sub    = (op_r == 3'b001);
        is_arith  = (op_r[2:1] == 2'b00);
        b_eff     = b_sr[0] ^ is_sub;
        c_next    = (a_sr[0] & b_eff) | (a_sr[0] & c) | (b_eff & c);
        last_bit  = (cnt == CW'(WIDTH - 1));
        bit_out   = 1'b0;
        case (op_r)
            3'b000,
            3'b001:  bit_out = a_sr[0] ^ b_eff ^ c;
            3'b010:  bit_out = a_sr[0] ^ b_sr[0];
            3'b011:  bit_out = a_sr[0] & b_sr[0];
            3'b100:  bit_out = ~a_sr[0];
            3'b101:  bit_out = a_sr[0] | b_sr[0];
            3'b110:  bit_out = ~(a_sr[0] | b_sr[0]);
            default: bit_out = ~(a_sr[0] & b_sr[0]);
        endcase
        res_final = {bit_out, res_sr[WIDTH-1:1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge reclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

`ifdef SERIAL_ALU_OVF_EN
    logic ovf_r;
    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Visible outputs change only at acceptance (result cleared) and on the final shift
    always_ff @(posedge reclk or negedge rst) begin
        if (!rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            op_r   <= 3'b000;
            cnt    <= '0;
            c      <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        op_r   <= op;
                        cnt    <= '0;
                        res_sr <= '0;
                        result <= '0;
                        c      <= (op == 3'b001);
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_final;
                    if (is_arith) c <= c_next;
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        result <= res_final;
                        carry  <= is_arith & c_next;
                        zero   <= (res_final == '0);
`ifdef SERIAL_ALU_OVF_EN
                        ovf_r  <= is_arith && (a_sr[0] == b_eff) && (bit_out != a_sr[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq (WIDTH=8): directed vectors push expectations, a monitor checks each done pulse.
// Expected ovf follows SERIAL_ALU_OVF_EN, matching the build of the design.
module tb_serial_alu_seq;

    localparam int WIDTH = 8;
`ifdef SERIAL_ALU_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic             reclk, rst, start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, carry, zero, ovf;
    logic [WIDTH-1:0] result;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cy;
        logic             z;
        logic             v;
        int               k;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .reclk (reclk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result),
        .carry (carry),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial begin
        reclk = 1'b0;
        forever #5 reclk = ~reclk;
    end

    always @(posedge reclk) cyc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge reclk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("result", 64'(result), 64'(e.res));
                check_output("carry", 64'(carry), 64'(e.cy));
                check_output("zero", 64'(zero), 64'(e.z));
                check_output("ovf", 64'(ovf), 64'(e.v));
                check_output("busy_in_done", 64'(busy), 64'd1);
                check_output("latency", 64'(cyc - e.k), 64'(WIDTH));
            end
        end
    end

    task automatic wait_cyc(input int t);
        do @(negedge reclk); while (cyc < t);
    endtask

    task automatic apply_stimulus(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                                  input logic [7:0] er, input logic ecy, input logic ez, input logic ev,
                                  input bit expect_done, output int k);
        int n;
        n = 0;
        @(negedge reclk);
        while (busy && n < 50) begin
            @(negedge reclk);
            n++;
        end
        if (busy) begin
            checks++;
            fails++;
            $display("[TB] FAIL idle_timeout: got busy=1, expected 0");
        end
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge reclk);
        #1;
        start = 1'b0;
        k = cyc;
        if (expect_done) sb.push_back('{er, ecy, ez, OVF_ON & ev, k});
    endtask

    initial begin
        int k;
        int n;
        rst   = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge reclk);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);
        check_output("reset_result", 64'(result), 64'd0);
        check_output("reset_carry", 64'(carry), 64'd0);
        check_output("reset_zero", 64'(zero), 64'd0);
        check_output("reset_ovf", 64'(ovf), 64'd0);
        rst = 1'b1;

        apply_stimulus(3'b000, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b1, k);
        check_output("busy_after_accept", 64'(busy), 64'd1);
        apply_stimulus(3'b001, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, k);
        apply_stimulus(3'b111, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1, k);

        // Starts landing in SHIFT (edge k+3) and DONE (edge k+9) must be ignored
        apply_stimulus(3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1, k);
        wait_cyc(k + 2);
        start = 1'b1; op = 3'b111; a = 8'h00; b = 8'hFF;
        @(negedge reclk);
        start = 1'b0;
        wait_cyc(k + 8);
        start = 1'b1; op = 3'b110; a = 8'h00; b = 8'h00;
        @(negedge reclk);
        start = 1'b0;
        apply_stimulus(3'b100, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, k);

        apply_stimulus(3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, k);

        // Reset mid-operation abandons the add; no done pulse may follow
        apply_stimulus(3'b000, 8'h3C, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, k);
        wait_cyc(k + 3);
        rst = 1'b0;
        #1;
        check_output("midreset_busy", 64'(busy), 64'd0);
        check_output("midreset_done", 64'(done), 64'd0);
        check_output("midreset_result", 64'(result), 64'd0);
        check_output("midreset_carry", 64'(carry), 64'd0);
        check_output("midreset_zero", 64'(zero), 64'd0);
        repeat (2) @(negedge reclk);
        rst = 1'b1;
        repeat (12) @(negedge reclk);

        apply_stimulus(3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, k);
        apply_stimulus(3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, k);
        apply_stimulus(3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b1, k);
        apply_stimulus(3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, k);

        n = 0;
        while ((sb.size() != 0 || busy) && n < 40) begin
            @(negedge reclk);
            n++;
        end
        check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
        check_output("final_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Parametrised bit-serial ALU sequencer: accepts two WIDTH-bit operands and a 3-bit opcode, then processes one bit per clock, LSB first, through a single-bit add/logic slice with a registered carry. It extends the single-bit serial ALU to whole words: internal operand shift registers, a bit counter and a start/done handshake. It sits between the operand register file and result write-back, and serves as the word-level arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64

- reclk  in  1  sole clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  opcode: 000 add, 001 sub, 010 xor, 011 and, 100 not(a), 101 or, 110 nor, 111 nand
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse; result/flags valid
- result  out  WIDTH  result word; held until the next accepted start
- carry  out  1  final carry for add/sub (sub: 1 = no borrow); 0 for logic ops
- zero  out  1  result == 0
- ovf  out  1  signed overflow (see Configuration)

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset enters IDLE.
- IDLE, start=1:
  - Load a, b into shift registers and latch op.
  - Clear the bit counter and clear result.
  - Init carry register: 1 for sub, 0 otherwise.
  - Go to SHIFT.
- IDLE, start=0: hold all outputs.
- SHIFT, each edge:
  - Compute bit = f(a_sr[0], b_sr[0]^sub, c).
  - Shift bit into result MSB, so that after WIDTH shifts result[0] is the first bit.
  - Shift a_sr and b_sr right by one.
  - c <= majority(a0, b0^sub, c) for add/sub; c is unchanged for logic ops.
  - Increment the counter.
  - When the counter reaches WIDTH-1 on this edge, go to DONE.
- DONE:
  - done=1, busy=1.
  - carry = c for add/sub, 0 otherwise.
  - zero = (result == 0).
  - Next edge: go to IDLE.
- start while busy (SHIFT or DONE): ignored, no effect. Op and operand changes after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH.
- Sub computes a + ~b + 1.
- not(a) ignores b.
- Reset mid-operation: all state clears immediately and the operation is abandoned; no done pulse.

## Timing
- Reset values: busy=0, done=0, result=0, carry=0, zero=0, ovf=0. All outputs are registered; no combinational input-to-output paths.
- start accepted at edge k: busy=1 after k; done=1 for exactly the cycle after edge k+WIDTH. Latency is WIDTH+1 cycles.
- busy falls after edge k+WIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 cycles. start held high continuously re-triggers on the first IDLE cycle.
- result, carry, zero and ovf update only at the DONE transition and stay stable until the next accepted start.
- Counter width is clog2(WIDTH); no wrap occurs, because the FSM leaves SHIFT at WIDTH-1.

## Configuration
- SERIAL_ALU_OVF_EN defined:
  - An extra register samples the sign of the operands at the final SHIFT bit.
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb), valid in DONE for add/sub, where b' is b inverted for sub.
  - ovf = 0 for logic ops.
- SERIAL_ALU_OVF_EN undefined: the ovf port remains and is tied to 0; no extra logic.

## Test plan
- WIDTH=8, add a=0x3C b=0x0F, start at edge 0 -> done at cycle 9, result=0x4B, carry=0, zero=0.
- add a=0xFF b=0x01 -> result=0x00, carry=1, zero=1; sub a=0x05 b=0x05 -> result=0x00, carry=1, zero=1.
- sub a=0x10 b=0x20 -> result=0xF0, carry=0 (borrow); nand a=0xF0 b=0xCC -> result=0x3F, carry=0.
- start pulsed again at cycles 3 and 9 during an add -> ignored, single done, original result. Then start at IDLE with op=100, a=0xA5 -> result=0x5A.
- rst low at cycle 4 of an operation -> busy, done, result and carry all 0 immediately; no done pulse; the next start runs normally.
- With SERIAL_ALU_OVF_EN: add 0x7F+0x01 -> result=0x80, ovf=1; sub 0x80-0x01 -> result=0x7F, ovf=1; add 0x01+0x01 -> ovf=0. Without the macro: ovf=0 in all three cases.
